// File: rtl/mac_t_sched_mq.sv
// rtl/mac_t_sched_mq.sv - N-channel TX frame scheduler with runt padding and inter-frame gap
// Optional PTP timestamp/type tagging is enabled with the PTP_TAG_EN macro.
module mac_t_sched_mq #(
    parameter int CH_NUM   = 4,
    parameter int LEN_W    = 11,
    parameter int MIN_LEN  = 60,
    parameter int IFG_CYC  = 2,
    parameter int ARB_MODE = 0
) (
    input  logic                      sys_clk,
    input  logic                      rstn_sys,
    output logic [CH_NUM-1:0]         ptr_fifo_rd,
    input  logic [CH_NUM*16-1:0]      ptr_fifo_din,
    input  logic [CH_NUM-1:0]         ptr_fifo_empty,
    output logic [CH_NUM-1:0]         data_fifo_rd,
    input  logic [CH_NUM*8-1:0]       data_fifo_din,
    input  logic [CH_NUM-1:0]         data_fifo_empty,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [7:0]                out_data,
    output logic                      out_sop,
    output logic                      out_eop,
    output logic [$clog2(CH_NUM)-1:0] out_ch,
    output logic                      len_err
`ifdef PTP_TAG_EN
    ,
    input  logic [31:0]               counter_ns,
    output logic [31:0]               ptp_ts,
    output logic [3:0]                ptp_type,
    output logic                      ptp_vld
`endif
);

    localparam int CW = $clog2(CH_NUM);
    localparam int GW = $clog2(IFG_CYC + 1) + 1;
    localparam logic [LEN_W-1:0] MIN_L = LEN_W'(MIN_LEN);

    typedef enum logic [2:0] {
        S_IDLE,
        S_PTR,
        S_LEN,
        S_DATA,
        S_PAD,
        S_GAP
    } state_t;

    state_t            state_q;
    logic [CW-1:0]     grant_q, rr_q, grant_d;
    logic              grant_vld;
    int                rr_idx;
    logic [CH_NUM-1:0] ptr_rd_q;
    logic [LEN_W-1:0]  len_q, rd_cnt_q, push_cnt_q, total_len, ptr_len;
    logic [GW-1:0]     gap_q;
    logic              len_err_q, inflight_q;
    logic [1:0]        cnt_q;
    logic [7:0]        d0_q, d1_q, data_byte, push_byte;
    logic              sop0_q, sop1_q, eop0_q, eop1_q;
    logic              rd_go, pad_go, push, push_sop, push_eop, pop, eop_hs;
    logic              unused_ptr_bits;

    assign unused_ptr_bits = ^ptr_fifo_din;

    // Strict: highest non-empty index. Round-robin: first non-empty after last grant.
    always_comb begin
        grant_d   = '0;
        grant_vld = 1'b0;
        rr_idx    = 0;
        if (ARB_MODE == 0) begin
            for (int i = 0; i < CH_NUM; i++) begin
                if (!ptr_fifo_empty[i]) begin
                    grant_d   = CW'(i);
                    grant_vld = 1'b1;
                end
            end
        end else begin
            for (int i = CH_NUM; i >= 1; i--) begin
                rr_idx = (int'(rr_q) + i) % CH_NUM;
                if (!ptr_fifo_empty[rr_idx]) begin
                    grant_d   = CW'(rr_idx);
                    grant_vld = 1'b1;
                end
            end
        end
    end

    assign ptr_len   = ptr_fifo_din[16*grant_q +: LEN_W];
    assign data_byte = data_fifo_din[8*grant_q +: 8];
    assign total_len = (len_q < MIN_L) ? MIN_L : len_q;

    // Reads are throttled so skid entries plus the in-flight byte never exceed two.
    assign rd_go  = (state_q == S_DATA) && !data_fifo_empty[grant_q] &&
                    ((cnt_q + {1'b0, inflight_q}) < 2'd2) && (rd_cnt_q < len_q);
    assign pad_go = (state_q == S_PAD) && !inflight_q && (cnt_q != 2'd2) &&
                    (push_cnt_q < total_len);

    assign push      = inflight_q || pad_go;
    assign push_byte = inflight_q ? data_byte : 8'h00;
    assign push_sop  = (push_cnt_q == '0);
    assign push_eop  = (push_cnt_q == total_len - 1'b1);
    assign out_valid = (cnt_q != 2'd0);
    assign pop       = out_valid && out_ready;
    assign eop_hs    = pop && eop0_q;

    assign data_fifo_rd = rd_go ? (CH_NUM'(1) << grant_q) : '0;
    assign ptr_fifo_rd  = ptr_rd_q;
    assign out_data     = d0_q;
    assign out_sop      = sop0_q;
    assign out_eop      = eop0_q;
    assign out_ch       = grant_q;
    assign len_err      = len_err_q;

    always_ff @(posedge sys_clk or negedge rstn_sys) begin
        if (!rstn_sys) begin
            state_q    <= S_IDLE;
            grant_q    <= '0;
            rr_q       <= '0;
            ptr_rd_q   <= '0;
            len_q      <= '0;
            rd_cnt_q   <= '0;
            push_cnt_q <= '0;
            gap_q      <= '0;
            len_err_q  <= 1'b0;
            inflight_q <= 1'b0;
        end else begin
            ptr_rd_q   <= '0;
            len_err_q  <= 1'b0;
            inflight_q <= rd_go;
            if (push) begin
                push_cnt_q <= push_cnt_q + 1'b1;
            end
            case (state_q)
                S_IDLE: begin
                    if (grant_vld) begin
                        grant_q  <= grant_d;
                        rr_q     <= grant_d;
                        ptr_rd_q <= CH_NUM'(1) << grant_d;
                        state_q  <= S_PTR;
                    end
                end
                S_PTR: state_q <= S_LEN;
                S_LEN: begin
                    len_q      <= ptr_len;
                    rd_cnt_q   <= '0;
                    push_cnt_q <= '0;
                    if (ptr_len == '0) begin
                        len_err_q <= 1'b1;
                        gap_q     <= GW'(IFG_CYC);
                        state_q   <= S_GAP;
                    end else begin
                        state_q <= S_DATA;
                    end
                end
                S_DATA: begin
                    if (rd_go) begin
                        rd_cnt_q <= rd_cnt_q + 1'b1;
                    end
                    if ((rd_cnt_q == len_q) && (len_q < MIN_L)) begin
                        state_q <= S_PAD;
                    end else if (eop_hs) begin
                        gap_q   <= GW'(IFG_CYC);
                        state_q <= S_GAP;
                    end
                end
                S_PAD: begin
                    if (eop_hs) begin
                        gap_q   <= GW'(IFG_CYC);
                        state_q <= S_GAP;
                    end
                end
                S_GAP: begin
                    if (gap_q <= GW'(1)) begin
                        state_q <= S_IDLE;
                    end else begin
                        gap_q <= gap_q - 1'b1;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    // Two-entry skid buffer; entry 0 is the head driving out_*.
    always_ff @(posedge sys_clk or negedge rstn_sys) begin
        if (!rstn_sys) begin
            cnt_q  <= 2'd0;
            d0_q   <= 8'h00;
            d1_q   <= 8'h00;
            sop0_q <= 1'b0;
            sop1_q <= 1'b0;
            eop0_q <= 1'b0;
            eop1_q <= 1'b0;
        end else begin
            cnt_q <= cnt_q + {1'b0, push} - {1'b0, pop};
            if (pop && (!push || cnt_q == 2'd2)) begin
                d0_q   <= d1_q;
                sop0_q <= sop1_q;
                eop0_q <= eop1_q;
            end
            if (push) begin
                if (cnt_q == 2'd0 || (cnt_q == 2'd1 && pop)) begin
                    d0_q   <= push_byte;
                    sop0_q <= push_sop;
                    eop0_q <= push_eop;
                end else begin
                    d1_q   <= push_byte;
                    sop1_q <= push_sop;
                    eop1_q <= push_eop;
                end
            end
        end
    end

`ifdef PTP_TAG_EN
    logic [LEN_W-1:0] acc_idx_q;
    logic [31:0]      ts_q;
    logic [3:0]       type_q;
    logic             m12_q, m13_q, ptp_vld_q;

    // Bytes 12..13 carry the EtherType; 0x88F7 marks a PTP frame.
    always_ff @(posedge sys_clk or negedge rstn_sys) begin
        if (!rstn_sys) begin
            acc_idx_q <= '0;
            ts_q      <= '0;
            type_q    <= '0;
            m12_q     <= 1'b0;
            m13_q     <= 1'b0;
            ptp_vld_q <= 1'b0;
        end else begin
            ptp_vld_q <= eop_hs && m12_q && m13_q;
            if (pop) begin
                acc_idx_q <= eop0_q ? '0 : acc_idx_q + 1'b1;
                if (sop0_q) begin
                    ts_q <= counter_ns;
                end
                if (acc_idx_q == LEN_W'(12)) begin
                    m12_q <= (d0_q == 8'h88);
                end
                if (acc_idx_q == LEN_W'(13)) begin
                    m13_q <= (d0_q == 8'hF7);
                end
                if (acc_idx_q == LEN_W'(14)) begin
                    type_q <= d0_q[3:0];
                end
            end
        end
    end

    assign ptp_ts   = ts_q;
    assign ptp_type = type_q;
    assign ptp_vld  = ptp_vld_q;
`endif

endmodule

// File: tb/tb_mac_t_sched_mq.sv
// tb/tb_mac_t_sched_mq.sv - scoreboard bench for mac_t_sched_mq (strict and round-robin instances)
`timescale 1ns/1ps
module tb_mac_t_sched_mq;
    localparam int CH   = 4;
    localparam int MINL = 60;
    localparam int IFG  = 2;

    logic sys_clk  = 1'b0;
    logic rstn_sys = 1'b0;
    always #5 sys_clk = ~sys_clk;

    logic [CH-1:0]    ptr_fifo_rd, ptr_fifo_empty, data_fifo_rd, data_fifo_empty;
    logic [CH*16-1:0] ptr_fifo_din = '0;
    logic [CH*8-1:0]  data_fifo_din = '0;
    logic             out_valid, out_sop, out_eop, len_err;
    logic             out_ready = 1'b1;
    logic [7:0]       out_data;
    logic [1:0]       out_ch;

    logic [CH-1:0] rr_ptr_rd, rr_data_rd;
    logic          rr_valid, rr_sop, rr_eop, rr_len_err;
    logic [7:0]    rr_data;
    logic [1:0]    rr_ch;

`ifdef PTP_TAG_EN
    logic [31:0] ts, rr_ts;
    logic [3:0]  ty, rr_ty;
    logic        pv, rr_pv;
    logic [31:0] ns_cnt = '0;
    always @(posedge sys_clk) ns_cnt <= ns_cnt + 32'd10;
`endif

    mac_t_sched_mq #(.ARB_MODE(0)) dut (
`ifdef PTP_TAG_EN
        .counter_ns(ns_cnt), .ptp_ts(ts), .ptp_type(ty), .ptp_vld(pv),
`endif
        .sys_clk(sys_clk), .rstn_sys(rstn_sys),
        .ptr_fifo_rd(ptr_fifo_rd), .ptr_fifo_din(ptr_fifo_din), .ptr_fifo_empty(ptr_fifo_empty),
        .data_fifo_rd(data_fifo_rd), .data_fifo_din(data_fifo_din), .data_fifo_empty(data_fifo_empty),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_sop(out_sop), .out_eop(out_eop), .out_ch(out_ch), .len_err(len_err)
    );

    mac_t_sched_mq #(.ARB_MODE(1)) dut_rr (
`ifdef PTP_TAG_EN
        .counter_ns(ns_cnt), .ptp_ts(rr_ts), .ptp_type(rr_ty), .ptp_vld(rr_pv),
`endif
        .sys_clk(sys_clk), .rstn_sys(rstn_sys),
        .ptr_fifo_rd(rr_ptr_rd), .ptr_fifo_din({CH{16'd60}}), .ptr_fifo_empty(4'b0000),
        .data_fifo_rd(rr_data_rd), .data_fifo_din({CH{8'h55}}), .data_fifo_empty(4'b0000),
        .out_valid(rr_valid), .out_ready(1'b1), .out_data(rr_data),
        .out_sop(rr_sop), .out_eop(rr_eop), .out_ch(rr_ch), .len_err(rr_len_err)
    );

    // FIFO models with one-cycle read latency
    logic [15:0]   pmem [CH][16];
    logic [7:0]    dmem [CH][512];
    int            pwr[CH], prd[CH], dwr[CH], drd[CH];
    logic [CH-1:0] hold = '0;
    logic          rand_en = 1'b0;

    always_comb begin
        for (int c = 0; c < CH; c++) begin
            ptr_fifo_empty[c]  = (prd[c] == pwr[c]);
            data_fifo_empty[c] = (drd[c] == dwr[c]) || hold[c];
        end
    end

    always @(posedge sys_clk) begin
        for (int c = 0; c < CH; c++) begin
            if (ptr_fifo_rd[c]) begin
                ptr_fifo_din[16*c +: 16] <= pmem[c][prd[c] % 16];
                prd[c] <= prd[c] + 1;
            end
            if (data_fifo_rd[c]) begin
                data_fifo_din[8*c +: 8] <= dmem[c][drd[c] % 512];
                drd[c] <= drd[c] + 1;
            end
        end
    end

    initial forever begin
        @(posedge sys_clk);
        #1;
        out_ready = rand_en ? 1'($urandom_range(0, 1)) : 1'b1;
        hold      = rand_en ? {1'b0, 1'($urandom_range(0, 1)), 2'b00} : 4'b0000;
    end

    logic [11:0] exp_q[$];
    logic [11:0] exp_e;
    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: actual 0x%0h required 0x%0h", name, act, req);
        end
    endtask

    task automatic load_data(input int ch, input int len, input int base);
        for (int i = 0; i < len; i++) begin
            dmem[ch][dwr[ch] % 512] = 8'(base + i);
            dwr[ch] = dwr[ch] + 1;
            exp_q.push_back({2'(ch), (i == 0), (len >= MINL) && (i == len - 1), 8'(base + i)});
        end
        for (int i = len; i < MINL && len > 0; i++) begin
            exp_q.push_back({2'(ch), 1'b0, (i == MINL - 1), 8'h00});
        end
    endtask

    task automatic load_ptr(input int ch, input int len);
        pmem[ch][pwr[ch] % 16] = 16'(len);
        pwr[ch] = pwr[ch] + 1;
    endtask

    task automatic wait_drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 4000) begin
            @(negedge sys_clk);
            n++;
        end
        chk("drain_timeout", exp_q.size(), 0);
        repeat (10) @(negedge sys_clk);
    endtask

    int         cyc = 0;
    int         last_eop_cyc = -100;
    int         valid_cyc = 0;
    int         len_err_cnt = 0;
    int         rd_pulses[CH];
    logic       prev_stall = 1'b0;
    logic       prev_len_err = 1'b0;
    logic [7:0] prev_data = 8'h00;

    always @(negedge sys_clk) begin
        cyc++;
        if (rstn_sys) begin
            if (prev_stall) begin
                chk("hold_valid", out_valid, 1);
                chk("hold_data", out_data, prev_data);
            end
            if (out_valid) valid_cyc++;
            if (len_err) begin
                len_err_cnt++;
                chk("len_err_width", {prev_len_err, len_err}, 2'b01);
            end
            if (|data_fifo_rd) chk("rd_when_empty", data_fifo_rd & data_fifo_empty, 0);
            for (int c = 0; c < CH; c++) if (data_fifo_rd[c]) rd_pulses[c]++;
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_byte: actual 0x%0h required none", out_data);
                end else begin
                    exp_e = exp_q.pop_front();
                    chk("out_byte", {out_ch, out_sop, out_eop, out_data}, exp_e);
                end
                if (out_sop) chk("ifg", (cyc - last_eop_cyc > IFG + 1), 1);
                if (out_eop) last_eop_cyc = cyc;
            end
            prev_stall   = out_valid && !out_ready;
            prev_data    = out_data;
            prev_len_err = len_err;
        end
    end

    int rr_k = 0;
    always @(negedge sys_clk) begin
        if (rstn_sys && (|rr_ptr_rd) && rr_k < 8) begin
            chk("rr_grant", rr_ptr_rd, 32'd1 << ((rr_k + 1) % 4));
            rr_k++;
        end
    end

    int r0, l0, v0, s0, s1;

    initial begin
        repeat (3) @(negedge sys_clk);
        chk("rst_valid", out_valid, 0);
        chk("rst_sop_eop", {out_sop, out_eop}, 0);
        chk("rst_data", out_data, 0);
        chk("rst_ch", out_ch, 0);
        chk("rst_ptr_rd", ptr_fifo_rd, 0);
        chk("rst_data_rd", data_fifo_rd, 0);
        chk("rst_len_err", len_err, 0);
        rstn_sys = 1'b1;
        repeat (3) @(negedge sys_clk);

        load_data(0, 64, 8'h00);
        load_ptr(0, 64);
        wait_drain();

        load_data(3, 61, 8'h80);
        load_data(0, 20, 8'hA0);
        load_ptr(3, 61);
        load_ptr(0, 20);
        wait_drain();

        r0 = rd_pulses[1];
        load_data(1, 10, 8'h11);
        load_ptr(1, 10);
        wait_drain();
        chk("pad_rd_pulses", rd_pulses[1] - r0, 10);

        rand_en = 1'b1;
        load_data(2, 100, 8'h40);
        load_ptr(2, 100);
        wait_drain();
        rand_en = 1'b0;
        repeat (3) @(negedge sys_clk);

        l0 = len_err_cnt;
        v0 = valid_cyc;
        s0 = rd_pulses[0] + rd_pulses[1] + rd_pulses[2] + rd_pulses[3];
        load_ptr(2, 0);
        repeat (20) @(negedge sys_clk);
        s1 = rd_pulses[0] + rd_pulses[1] + rd_pulses[2] + rd_pulses[3];
        chk("len0_err_pulses", len_err_cnt - l0, 1);
        chk("len0_valid_cycles", valid_cyc - v0, 0);
        chk("len0_data_reads", s1 - s0, 0);

        for (int n = 0; n < 2000 && rr_k < 8; n++) @(negedge sys_clk);
        chk("rr_grants_seen", rr_k, 8);
        chk("scoreboard_empty", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
